// File: rtl/wb_trig_master_if.sv
// Bundle of the command/response streams and the Wishbone classic bus seen by wb_trig_master.
interface wb_trig_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat, rsp_ready, wb_dat_i, wb_ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat, rsp_ready, wb_dat_i, wb_ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
  );
endinterface

// File: rtl/wb_trig_master.sv
// Single-outstanding Wishbone classic initiator: command stream in, one bus cycle,
// response stream out, with a watchdog that ends cycles a dead responder never acks.
module wb_trig_master #(
  parameter int TIMEOUT = 256
) (
  input logic             clk,
  input logic             reset,
  wb_trig_master_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam int LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             cmd_ready;
  logic             cyc, cyc_n;
  logic             we, we_n;
  logic [31:0]      adr, adr_n;
  logic [3:0]       sel, sel_n;
  logic [31:0]      dat, dat_n;
  logic             rsp_valid, rsp_valid_n;
  logic             rsp_err, rsp_err_n;
  logic [31:0]      rsp_dat, rsp_dat_n;
  logic             expire;

  // Watchdog fires on the edge that ends the TIMEOUT-th strobe cycle.
  assign expire = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cyc_n       = cyc;
    we_n        = we;
    adr_n       = adr;
    sel_n       = sel;
    dat_n       = dat;
    rsp_valid_n = rsp_valid;
    rsp_err_n   = rsp_err;
    rsp_dat_n   = rsp_dat;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_n = BUS;
          cyc_n   = 1'b1;
          we_n    = bus.cmd_we;
          adr_n   = bus.cmd_adr;
          sel_n   = bus.cmd_sel;
          dat_n   = bus.cmd_dat;
          cnt_n   = '0;
        end
      end
      BUS: begin
        if (bus.wb_ack_i) begin
          state_n     = RSP;
          cyc_n       = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_dat_n   = we ? 32'h0 : bus.wb_dat_i;
        end else if (expire) begin
          state_n     = RSP;
          cyc_n       = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_dat_n   = 32'h0;
        end else if (cnt != {CNT_W{1'b1}}) begin
          cnt_n = cnt + 1'b1;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      cyc       <= 1'b0;
      we        <= 1'b0;
      adr       <= '0;
      sel       <= '0;
      dat       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cmd_ready <= (state_n == IDLE);
      cyc       <= cyc_n;
      we        <= we_n;
      adr       <= adr_n;
      sel       <= sel_n;
      dat       <= dat_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_dat   <= rsp_dat_n;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_dat   = rsp_dat;
  assign bus.wb_cyc_o  = cyc;
  assign bus.wb_stb_o  = cyc;
  assign bus.wb_we_o   = we;
  assign bus.wb_adr_o  = adr;
  assign bus.wb_sel_o  = sel;
  assign bus.wb_dat_o  = dat;
endmodule
